// File: rtl/tis_port_arbiter_if.sv
// Bundle of the requester-side and node-side handshake signals of the
// TIS-100 port arbiter. The arbiter uses the slave modport; whoever drives
// the requesters and the node input port uses the master modport.
interface tis_port_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 11
);
    localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic                out_ready;
    logic [SW-1:0]       out_src;
    logic [15:0]         xfer_cnt;

    modport slave (
        input  req_valid,
        input  req_data,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_data,
        output out_src,
        output xfer_cnt
    );

    modport master (
        output req_valid,
        output req_data,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_data,
        input  out_src,
        input  xfer_cnt
    );
endinterface

// File: rtl/tis_port_arbiter.sv
// Round-robin arbiter that funnels N_REQ requesters into one registered
// node input port. A single output register is either empty (IDLE) or full
// (HOLD). It can be refilled in the same cycle the node drains it, so a
// stream of requests is delivered at one word per cycle.
module tis_port_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tis_port_arbiter_if.slave    bus
);
    localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   out_data_q;
    logic [SW-1:0]   out_src_q;
    logic [SW-1:0]   ptr_q;
    logic [15:0]     xfer_cnt_q;

    logic            win_found_s;
    logic [SW-1:0]   win_idx_s;
    logic            slot_free_s;
    logic            grant_s;
    logic            accept_s;
    logic [N_REQ-1:0] req_ready_s;

    // Round-robin search: the first valid requester after the last winner.
    always_comb begin
        int          cand;
        logic [SW-1:0] cand_idx;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand     = (int'(ptr_q) + k) % N_REQ;
            cand_idx = SW'(cand);
            if (!win_found_s && bus.req_valid[cand_idx]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_idx;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Slot availability, grant strobe and the node-side accept.
    always_comb begin
        // Held low during reset so no requester sees a grant that cannot land.
        slot_free_s = rst_n && ((state_q == ST_IDLE) || bus.out_ready);
        grant_s     = slot_free_s && win_found_s;
        accept_s    = (state_q == ST_HOLD) && bus.out_ready;
        req_ready_s = '0;
        if (grant_s) begin
            req_ready_s[win_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Next-state logic for the output register occupancy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = grant_s ? ST_HOLD : ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; a held word is dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winning word, its source and the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_src_q  <= '0;
            ptr_q      <= SW'(N_REQ - 1);
        end else if (grant_s) begin
            out_data_q <= bus.req_data[win_idx_s*DW +: DW];
            out_src_q  <= win_idx_s;
            ptr_q      <= win_idx_s;
        end else begin
            out_data_q <= out_data_q;
            out_src_q  <= out_src_q;
            ptr_q      <= ptr_q;
        end
    end

    // Delivered-word counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q <= 16'd0;
        end else if (accept_s) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end else begin
            xfer_cnt_q <= xfer_cnt_q;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.xfer_cnt  = xfer_cnt_q;

endmodule

// File: doc/tis_port_arbiter.md
TIS_PORT_ARBITER -- requirements
Module: tis_port_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk (rising edge), rst_n (asynchronous assert, active-low).
REQ-002 Parameter N_REQ, default 4: number of requesters sharing one node input port.
REQ-003 Parameter DW, default 11: word width; holds TIS-100 values -999..999 as two's complement.
REQ-004 Port clk  input  1  system clock.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port req_valid  input  N_REQ  per-requester word-available flag.
REQ-007 Port req_data  input  N_REQ*DW  per-requester word; requester i occupies slice i.
REQ-008 Port req_ready  output  N_REQ  one-hot grant/accept strobe, combinational.
REQ-009 Port out_valid  output  1  word held for the node input port (in0..in3).
REQ-010 Port out_data  output  DW  registered word to the node.
REQ-011 Port out_ready  input  1  node accepts the word this cycle.
REQ-012 Port out_src  output  clog2(N_REQ)  index of the requester that supplied out_data.
REQ-013 Port xfer_cnt  output  16  count of words delivered to the node.

Function
REQ-014 The FSM SHALL have two states: IDLE (output register empty) and HOLD (output register full).
REQ-015 A slot is free when the FSM is in IDLE, or when it is in HOLD with out_ready=1.
REQ-016 Round-robin: when a slot is free and any req_valid is set, the winner SHALL be the first set req_valid searching from ptr+1 upward, modulo N_REQ.
REQ-017 req_ready SHALL be high only for the winner, only in a free-slot cycle, and all-zero otherwise.
REQ-018 A transfer occurs when req_valid[i] and req_ready[i] are both high. On that clock edge: out_data <= req_data slice i; out_src <= i; ptr <= i; state <= HOLD.
REQ-019 In HOLD, out_valid SHALL be 1, and out_data and out_src SHALL stay stable until out_ready=1.
REQ-020 HOLD with out_ready=1 and no req_valid SHALL go to IDLE on the next edge with out_valid=0.
REQ-021 HOLD with out_ready=1 and a req_valid present SHALL reload in the same cycle and stay in HOLD, giving one word per cycle with no bubble.
REQ-022 Latency: requester handshake at edge k makes out_valid=1 after edge k, visible in cycle k+1.
REQ-023 xfer_cnt SHALL increment by 1 on each edge where out_valid and out_ready are both high, and SHALL wrap from 65535 to 0.
REQ-024 A single active requester SHALL be granted on every free slot.
REQ-025 With all requesters active, each SHALL be granted exactly once per N_REQ consecutive transfers.
REQ-026 out_ready while in IDLE SHALL be ignored and SHALL not change xfer_cnt.
REQ-027 A req_valid that is deasserted before its grant SHALL lose no state; no request is latched.
REQ-028 out_data SHALL be passed unmodified; there is no range check or saturation.

Reset
REQ-029 While rst_n=0, and immediately on its assertion even mid-transfer: state=IDLE, out_valid=0, out_data=0, out_src=0, xfer_cnt=0, ptr=N_REQ-1, req_ready=all-zero.
REQ-030 A word held in HOLD when reset asserts SHALL be discarded.
REQ-031 The first grant after reset release SHALL search from requester 0.

Verification
REQ-032 Reset: assert rst_n=0 mid-HOLD -> out_valid=0, out_data=0, xfer_cnt=0 with no clock edge needed; after release, req_valid=0100 -> grant req_ready=0100, out_src=2.
REQ-033 Round-robin: req_valid=1111 held, out_ready=1 constant, data 10/20/30/40 -> out_src sequence 0,1,2,3,0; out_data 10,20,30,40,10; out_valid continuous; xfer_cnt=5 after 5 accepts.
REQ-034 Backpressure: req0 data -999, out_ready=0 for 7 cycles -> out_data=-999 stable, req_ready=0000 throughout; on out_ready=1, one accept and xfer_cnt+1.
REQ-035 Simultaneous events: in HOLD with src=1, out_ready=1 and req_valid=1010 -> same-cycle grant to requester 3, out_src=3 next cycle, no bubble.
REQ-036 Wrap: preset 65535 transfers (or force counter) then one more accept -> xfer_cnt=0.
REQ-037 Idle drain: a single word accepted with no further requests -> IDLE, out_valid=0; out_ready pulsed while idle -> xfer_cnt unchanged.
